// File: rtl/fpu_div_ctrl.sv
// rtl/fpu_div_ctrl.sv - issue/capture stage in front of a combinational single-precision divider
module fpu_div_ctrl #(
    parameter int NEXP          = 8,
    parameter int NSIG          = 23,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   in_a,
    input  logic [NEXP+NSIG:0]   in_b,
    output logic [NEXP+NSIG:0]   div_a,
    output logic [NEXP+NSIG:0]   div_b,
    input  logic [NEXP+NSIG:0]   div_d,
    input  logic                 div_o,
    input  logic                 div_v,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_d,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_invalid,
    output logic                 out_divzero
);
    localparam int W = NEXP + NSIG + 1;
    localparam logic [W-2:0] INF_MAG = {{NEXP{1'b1}}, {NSIG{1'b0}}};
    localparam logic [W-1:0] QNAN    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
    logic [W-1:0]   out_d_q, out_d_d;
    logic           out_valid_q, out_valid_d;
    logic           ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d, dz_q, dz_d;

    logic           a_exp_ones, b_exp_ones, a_frac_nz, b_frac_nz;
    logic           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;

    // Classifying the incoming words is equivalent to classifying div_a/div_b after the accepting edge.
    always_comb begin
        a_exp_ones = &in_a[W-2:NSIG];
        b_exp_ones = &in_b[W-2:NSIG];
        a_frac_nz  = |in_a[NSIG-1:0];
        b_frac_nz  = |in_b[NSIG-1:0];
        a_nan      = a_exp_ones && a_frac_nz;
        b_nan      = b_exp_ones && b_frac_nz;
        a_inf      = a_exp_ones && !a_frac_nz;
        b_inf      = b_exp_ones && !b_frac_nz;
        a_zero     = ~|in_a[W-2:NSIG];
        b_zero     = ~|in_b[W-2:NSIG];
        sgn        = in_a[W-1] ^ in_b[W-1];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        out_d_d     = out_d_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inv_d       = inv_q;
        dz_d        = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_a_d     = in_a;
                    div_b_d     = in_b;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    inv_d       = 1'b0;
                    dz_d        = 1'b0;
                    state_d     = RESULT;
                    out_valid_d = 1'b1;
                    if (a_nan || b_nan) begin
                        out_d_d = QNAN;
                        inv_d   = 1'b1;
                    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        out_d_d = QNAN;
                        inv_d   = 1'b1;
                    end else if (a_inf) begin
                        out_d_d = {sgn, INF_MAG};
                    end else if (b_zero) begin
                        out_d_d = {sgn, INF_MAG};
                        dz_d    = 1'b1;
                    end else if (a_zero || b_inf) begin
                        out_d_d = {sgn, {(W-1){1'b0}}};
                    end else begin
                        state_d     = SETTLE;
                        out_valid_d = 1'b0;
                        cnt_d       = 4'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_d_d     = div_d;
                    ovf_d       = div_o;
                    unf_d       = div_v;
                    inv_d       = 1'b0;
                    dz_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inv_q       <= inv_d;
            dz_q        <= dz_d;
        end
    end

    assign in_ready      = (state_q == IDLE) && !rst;
    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign out_valid     = out_valid_q;
    assign out_d         = out_d_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_invalid   = inv_q;
    assign out_divzero   = dz_q;
endmodule
